neural_unit_driver: RTL and testbench
=====================================

# neural_unit_driver

Initiator-side sequencer for the NeuralUnit weight-load/sum interface. Accepts one layer job from a host over a valid/ready handshake. For each job it:
- presents the four operands,
- writes the four weights with write pulses at addresses 0..3,
- fires sumTrigger,
- waits for a fresh rising edge on layerDone,
- returns layerOut (or a timeout flag) over a second valid/ready handshake.

It sits between the layer scheduler and each NeuralUnit instance.

## Interface
- DATA_W, 32, operand and result width
- WEIGHT_W, 8, weight width
- TIMEOUT, 255, max WAIT cycles before abort (≥1)

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  host job valid
- req_ready  out  1  high only in IDLE
- req_data  in  4*DATA_W  operands; slice k → inputk
- req_weight  in  4*WEIGHT_W  weights; slice k → address k
- req_layer  in  1  layer select for the job
- res_valid  out  1  result valid, held until res_ready
- res_ready  in  1  host accepts result
- res_data  out  DATA_W  captured layerOut; 0 on timeout
- res_timeout  out  1  job aborted by timeout
- input0..input3  out  DATA_W each  operands to NeuralUnit
- weight  out  WEIGHT_W  weight being written
- address  out  2  weight address
- write  out  1  weight write strobe
- sumTrigger  out  1  sum start strobe
- layer_Sel  out  1  layer select
- layerOut  in  DATA_W  NeuralUnit result
- layerDone  in  1  NeuralUnit done level; rising edge = completion

## Operation
- FSM states: IDLE, WR_HI, WR_LO, TRIG_HI, TRIG_LO, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: register req_data into input0..3, req_weight into an internal weight array, and req_layer into layer_Sel.
  - Set addr=0 and go to WR_HI.
- WR_HI: weight=array[addr], address=addr, write=1 → WR_LO.
- WR_LO: write=0, weight and address held.
  - If addr==3 → TRIG_HI.
  - Otherwise addr+1 → WR_HI.
- TRIG_HI: sumTrigger=1 → TRIG_LO.
- TRIG_LO: sumTrigger=0; clear the timeout counter → WAIT.
- Edge detector: done_q is a registered copy of layerDone, updated every cycle in every state. Edge = layerDone & ~done_q.
- WAIT:
  - On edge: capture layerOut into res_data, res_timeout=0 → RESP.
  - Otherwise increment the counter. When counter==TIMEOUT-1 with no edge: res_data=0, res_timeout=1 → RESP.
- RESP:
  - res_valid=1 with res_data and res_timeout stable.
  - On res_ready → IDLE.
  - req_valid is ignored while in RESP.
- Edges on layerDone outside WAIT are ignored; they are not remembered.
- A layerDone already high on entry to WAIT does not complete the job; a new rising edge is required.
- input0..3 and layer_Sel hold their values from acceptance until the next job is accepted.

## Timing
- Reset (async assert, sync release):
  - All outputs 0, req_ready=1 after release.
  - State IDLE, done_q=0, counter=0, weight array=0, res_data=0.
- Reset asserted mid-job aborts it immediately; no result is produced.
- Handshake at cycle 0, counted from the accepting edge:
  - WR_HI at cycles 1, 3, 5, 7 for addresses 0..3.
  - WR_LO at cycles 2, 4, 6, 8.
  - TRIG_HI at cycle 9, TRIG_LO at cycle 10, WAIT from cycle 11.
- Each write and sumTrigger is exactly one cycle high followed by at least one cycle low. weight and address are stable through both cycles.
- Result timing:
  - Edge sampled in WAIT at cycle n → res_valid=1 from cycle n+1.
  - res_ready sampled high at cycle m → IDLE and req_ready=1 at m+1.
- Back-to-back jobs have a minimum period of 13 cycles plus NeuralUnit latency.

## Configuration
- NEURAL_DRIVER_WCACHE_EN defined:
  - Keeps a shadow copy of the last weight written to each address, plus a valid bit cleared by reset.
  - Addresses whose new weight equals the valid shadow value are skipped; no WR_HI/WR_LO pair is issued for them.
  - If all four are skipped, the FSM goes from IDLE directly to TRIG_HI.
  - Shadow entry and valid bit update on each WR_HI.
- NEURAL_DRIVER_WCACHE_EN undefined: all four addresses are written on every job, with the fixed timing above.

## Test plan
- Reset, then job with data {0,1,2,3}, weights {0,1,2,3}, layer 0:
  - write pulses at cycles 1/3/5/7 with address 0..3 and weight 0..3.
  - sumTrigger at cycle 9.
  - Model asserts layerDone at cycle 15 with layerOut=14 → res_valid at 16, res_data=14, res_timeout=0.
- layerDone held high from before the job: no completion until it falls and rises again. res_data comes from the second rise.
- layerDone never rises, TIMEOUT=16 → res_valid with res_timeout=1, res_data=0. The next job completes normally.
- res_ready held low for 20 cycles while req_valid=1 → req_ready stays 0, result stays stable, no second job starts. Release res_ready → req_ready=1 next cycle.
- rst_n pulsed low during WR_HI of address 2:
  - Outputs go to 0 asynchronously.
  - After release, a new job writes all four addresses.
- With NEURAL_DRIVER_WCACHE_EN: two jobs with weights {1,2,3,4} then {1,9,3,4}:
  - Second job issues a single write (address 1, weight 9), then TRIG_HI.
  - An identical third job goes directly to TRIG_HI.

Source files
------------

// File: rtl/neural_unit_driver.sv
// -----------------------------------------------------------------------------
// neural_unit_driver
//
// Initiator-side sequencer for one NeuralUnit. It accepts a layer job from the
// host over a valid/ready handshake. For each job it drives the four operands,
// writes the four weights to addresses 0..3 using one-cycle write pulses, fires
// a one-cycle sumTrigger, and then waits for a fresh rising edge on layerDone.
// It returns layerOut, or a timeout flag if no edge arrives in time, over a
// second valid/ready handshake.
//
// Optional feature (macro NEURAL_DRIVER_WCACHE_EN):
//   The driver keeps a shadow copy of the last weight written to each address.
//   If a new weight equals the valid shadow value, that write is skipped.
//   When the macro is undefined, all four addresses are written on every job.
//
// Parameters:
//   DATA_W   - operand / result width
//   WEIGHT_W - weight width
//   TIMEOUT  - max WAIT cycles before the job is aborted (>= 1)
//
// Ports:
//   clk, rst_n            - clock (rising edge), async active-low reset
//   req_valid/req_ready   - job handshake (ready only in IDLE)
//   req_data              - four operands, slice k -> input k
//   req_weight            - four weights, slice k -> address k
//   req_layer             - layer select for the job
//   res_valid/res_ready   - result handshake (valid held until ready)
//   res_data, res_timeout - captured layerOut (0 on timeout), abort flag
//   input0..input3        - operands to the NeuralUnit
//   weight, address,write - weight write port to the NeuralUnit
//   sumTrigger, layer_Sel - sum start strobe, layer select
//   layerOut, layerDone   - NeuralUnit result and done level
// -----------------------------------------------------------------------------
module neural_unit_driver #(
    parameter int DATA_W   = 32,
    parameter int WEIGHT_W = 8,
    parameter int TIMEOUT  = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [4*DATA_W-1:0]   req_data,
    input  logic [4*WEIGHT_W-1:0] req_weight,
    input  logic                  req_layer,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_W-1:0]     res_data,
    output logic                  res_timeout,
    output logic [DATA_W-1:0]     input0,
    output logic [DATA_W-1:0]     input1,
    output logic [DATA_W-1:0]     input2,
    output logic [DATA_W-1:0]     input3,
    output logic [WEIGHT_W-1:0]   weight,
    output logic [1:0]            address,
    output logic                  write,
    output logic                  sumTrigger,
    output logic                  layer_Sel,
    input  logic [DATA_W-1:0]     layerOut,
    input  logic                  layerDone
);

    // The counter only ever needs to reach TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_HI   = 3'd1,
        WR_LO   = 3'd2,
        TRIG_HI = 3'd3,
        TRIG_LO = 3'd4,
        WAIT    = 3'd5,
        RESP    = 3'd6
    } state_t;

    state_t                state_reg;
    state_t                state_next;

    logic [1:0]            addr_reg;
    logic [1:0]            addr_next;
    logic [3:0]            need_reg;      // addresses this job still has to write
    logic [3:0]            req_need;      // addresses the incoming job must write
    logic [3:0]            pend_mask;     // remaining writes still ahead of addr_reg
    logic                  pend_any;
    logic [WEIGHT_W-1:0]   weight_arr [4];
    logic                  done_q;
    logic                  done_edge;
    logic [CNT_W-1:0]      cnt_reg;

    assign done_edge = layerDone & ~done_q;

    // ---------------------------------------------------------------------
    // Write-skip decision for the incoming job
    // ---------------------------------------------------------------------
`ifdef NEURAL_DRIVER_WCACHE_EN
    logic [WEIGHT_W-1:0] shadow_arr [4];
    logic [3:0]          shadow_valid;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_need
            assign req_need[gi] = !shadow_valid[gi] ||
                (shadow_arr[gi] != req_weight[gi*WEIGHT_W +: WEIGHT_W]);
        end
    endgenerate

    // The shadow copy tracks what the NeuralUnit really holds, so it is only
    // updated when a write strobe is actually issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_valid <= 4'b0;
            for (int k = 0; k < 4; k++) shadow_arr[k] <= '0;
        end else if (state_reg == WR_HI) begin
            shadow_arr[addr_reg]   <= weight_arr[addr_reg];
            shadow_valid[addr_reg] <= 1'b1;
        end
    end
`else
    assign req_need = 4'b1111;
`endif

    // Next address to write. In IDLE it is the first address the new job
    // needs. In WR_LO it is the next needed address above the current one.
    // An empty mask means that the weight phase is finished.
    always_comb begin
        pend_mask = 4'b0;
        addr_next = addr_reg;
        if (state_reg == IDLE)
            pend_mask = req_need;
        else if (state_reg == WR_LO)
            pend_mask = need_reg & (4'b1110 << addr_reg);
        for (int k = 3; k >= 0; k--)
            if (pend_mask[k]) addr_next = 2'(k);
    end

    assign pend_any = |pend_mask;

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // ---------------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req_valid) state_next = pend_any ? WR_HI : TRIG_HI;
            WR_HI:   state_next = WR_LO;
            WR_LO:   state_next = pend_any ? WR_HI : TRIG_HI;
            TRIG_HI: state_next = TRIG_LO;
            TRIG_LO: state_next = WAIT;
            WAIT:    if (done_edge || cnt_reg == CNT_LAST) state_next = RESP;
            RESP:    if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------------
    always_comb begin
        // req_ready is gated by rst_n so that every output reads 0 while
        // reset is held, and ready rises as soon as reset is released.
        req_ready  = (state_reg == IDLE) && rst_n;
        write      = (state_reg == WR_HI);
        sumTrigger = (state_reg == TRIG_HI);
        res_valid  = (state_reg == RESP);
    end

    // The weight and address buses follow the address register. They stay
    // stable through both WR_HI and WR_LO because addr_reg only advances
    // when WR_LO is left.
    assign weight  = weight_arr[addr_reg];
    assign address = addr_reg;

    // ---------------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg    <= 2'd0;
            need_reg    <= 4'b0;
            done_q      <= 1'b0;
            cnt_reg     <= '0;
            input0      <= '0;
            input1      <= '0;
            input2      <= '0;
            input3      <= '0;
            layer_Sel   <= 1'b0;
            res_data    <= '0;
            res_timeout <= 1'b0;
            for (int k = 0; k < 4; k++) weight_arr[k] <= '0;
        end else begin
            // Sampled every cycle, so edges seen outside WAIT are consumed.
            done_q <= layerDone;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        input0    <= req_data[0*DATA_W +: DATA_W];
                        input1    <= req_data[1*DATA_W +: DATA_W];
                        input2    <= req_data[2*DATA_W +: DATA_W];
                        input3    <= req_data[3*DATA_W +: DATA_W];
                        layer_Sel <= req_layer;
                        need_reg  <= req_need;
                        addr_reg  <= addr_next;
                        for (int k = 0; k < 4; k++)
                            weight_arr[k] <= req_weight[k*WEIGHT_W +: WEIGHT_W];
                    end
                end
                WR_LO: begin
                    if (pend_any) addr_reg <= addr_next;
                end
                TRIG_LO: begin
                    cnt_reg <= '0;
                end
                WAIT: begin
                    if (done_edge) begin
                        res_data    <= layerOut;
                        res_timeout <= 1'b0;
                    end else if (cnt_reg == CNT_LAST) begin
                        res_data    <= '0;
                        res_timeout <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neural_unit_driver.sv
// -----------------------------------------------------------------------------
// Testbench for neural_unit_driver. It uses directed jobs and checks the
// expected values inline. Inputs are driven, and outputs sampled, on the
// falling edge. Cycle 0 is the rising edge that accepts the request. "cyc"
// counts the falling edges after it, so cyc = n means cycle n.
// -----------------------------------------------------------------------------
module tb_neural_unit_driver;
    localparam int DW = 32;
    localparam int WW = 8;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [4*DW-1:0] req_data = '0;
    logic [4*WW-1:0] req_weight = '0;
    logic            req_layer = 1'b0;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [DW-1:0]   res_data;
    logic            res_timeout;
    logic [DW-1:0]   input0, input1, input2, input3;
    logic [WW-1:0]   weight;
    logic [1:0]      address;
    logic            write;
    logic            sumTrigger;
    logic            layer_Sel;
    logic [DW-1:0]   layerOut = '0;
    logic            layerDone = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int jobs = 0;

    always #5 clk = ~clk;

    neural_unit_driver #(.DATA_W(DW), .WEIGHT_W(WW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .req_weight(req_weight), .req_layer(req_layer),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_timeout(res_timeout),
        .input0(input0), .input1(input1), .input2(input2), .input3(input3),
        .weight(weight), .address(address), .write(write),
        .sumTrigger(sumTrigger), .layer_Sel(layer_Sel),
        .layerOut(layerOut), .layerDone(layerDone)
    );

    // Presents a job and returns just after the rising edge that accepts it.
    task automatic send(input logic [DW-1:0] d0, d1, d2, d3,
                        input logic [WW-1:0] w0, w1, w2, w3, input logic lay);
        int n = 0;
        @(negedge clk);
        req_data   = {d3, d2, d1, d0};
        req_weight = {w3, w2, w1, w0};
        req_layer  = lay;
        req_valid  = 1'b1;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_wait req_ready=%b expected 1", req_ready);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        cyc = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic release_result();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        layerDone = 1'b0;
        jobs++;
        $display("job %0d released: res_data=%0h res_timeout=%b", jobs, res_data, res_timeout);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({write, sumTrigger, res_valid, res_timeout} !== 4'b0) begin
            errors++;
            $display("FAIL reset_strobes got=%b expected 0000", {write, sumTrigger, res_valid, res_timeout});
        end
        checks++;
        if (address !== 2'd0 || weight !== 8'd0) begin
            errors++;
            $display("FAIL reset_wbus addr=%0d weight=%0d expected 0/0", address, weight);
        end
        checks++;
        if (input0 !== 0 || input3 !== 0 || layer_Sel !== 1'b0 || res_data !== 0) begin
            errors++;
            $display("FAIL reset_regs in0=%0h in3=%0h sel=%b res=%0h expected 0", input0, input3, layer_Sel, res_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready req_ready=%b expected 1", req_ready);
        end
    endtask

    task automatic test_basic();
        logic exp_w;
        send(32'd0, 32'd1, 32'd2, 32'd3, 8'd0, 8'd1, 8'd2, 8'd3, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            tick();
            exp_w = (cyc <= 8) && (cyc % 2 == 1);
            checks++;
            if (write !== exp_w) begin
                errors++;
                $display("FAIL basic_write cyc=%0d write=%b expected %b", cyc, write, exp_w);
            end
            if (cyc <= 8) begin
                checks++;
                if (address !== 2'((cyc - 1) / 2) || weight !== 8'((cyc - 1) / 2)) begin
                    errors++;
                    $display("FAIL basic_wbus cyc=%0d addr=%0d weight=%0d expected %0d", cyc, address, weight, (cyc - 1) / 2);
                end
            end
            checks++;
            if (sumTrigger !== (cyc == 9)) begin
                errors++;
                $display("FAIL basic_trig cyc=%0d sumTrigger=%b", cyc, sumTrigger);
            end
            checks++;
            if (res_valid !== (cyc >= 16)) begin
                errors++;
                $display("FAIL basic_res_valid cyc=%0d res_valid=%b", cyc, res_valid);
            end
            if (cyc == 15) begin
                layerDone = 1'b1;
                layerOut  = 32'd14;
            end
        end
        checks++;
        if (input0 !== 0 || input1 !== 1 || input2 !== 2 || input3 !== 3 || layer_Sel !== 1'b0) begin
            errors++;
            $display("FAIL basic_operands in=%0d,%0d,%0d,%0d sel=%b expected 0,1,2,3 sel 0", input0, input1, input2, input3, layer_Sel);
        end
        checks++;
        if (res_data !== 32'd14 || res_timeout !== 1'b0) begin
            errors++;
            $display("FAIL basic_result res_data=%0d timeout=%b expected 14/0", res_data, res_timeout);
        end
        release_result();
        checks++;
        if (req_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_return req_ready=%b res_valid=%b expected 1/0", req_ready, res_valid);
        end
    endtask

    task automatic test_done_held();
        layerDone = 1'b1;
        layerOut  = 32'd55;
        send(32'd4, 32'd5, 32'd6, 32'd7, 8'd10, 8'd11, 8'd12, 8'd13, 1'b1);
        for (int i = 1; i <= 19; i++) begin
            tick();
            checks++;
            if (res_valid !== (cyc >= 19)) begin
                errors++;
                $display("FAIL held_res_valid cyc=%0d res_valid=%b", cyc, res_valid);
            end
            if (cyc == 15) layerDone = 1'b0;
            if (cyc == 18) begin
                layerDone = 1'b1;
                layerOut  = 32'd77;
            end
        end
        checks++;
        if (res_data !== 32'd77 || res_timeout !== 1'b0 || layer_Sel !== 1'b1) begin
            errors++;
            $display("FAIL held_result res_data=%0d timeout=%b sel=%b expected 77/0/1", res_data, res_timeout, layer_Sel);
        end
        release_result();
    endtask

    task automatic test_timeout();
        layerOut = 32'hAAAA_5555;
        send(32'd8, 32'd9, 32'd10, 32'd11, 8'd20, 8'd21, 8'd22, 8'd23, 1'b0);
        for (int i = 1; i <= 27; i++) begin
            tick();
            checks++;
            if (res_valid !== (cyc >= 27)) begin
                errors++;
                $display("FAIL timeout_res_valid cyc=%0d res_valid=%b", cyc, res_valid);
            end
            // Pulses outside WAIT must be neither acted on nor remembered.
            layerDone = (cyc == 5) || (cyc == 10);
        end
        checks++;
        if (res_timeout !== 1'b1 || res_data !== 32'd0) begin
            errors++;
            $display("FAIL timeout_result timeout=%b res_data=%0h expected 1/0", res_timeout, res_data);
        end
        release_result();

        send(32'd1, 32'd1, 32'd1, 32'd1, 8'd30, 8'd31, 8'd32, 8'd33, 1'b1);
        for (int i = 1; i <= 13; i++) begin
            tick();
            checks++;
            if (res_valid !== (cyc >= 13)) begin
                errors++;
                $display("FAIL after_to_res_valid cyc=%0d res_valid=%b", cyc, res_valid);
            end
            if (cyc == 12) begin
                layerDone = 1'b1;
                layerOut  = 32'hDEAD_BEEF;
            end
        end
        checks++;
        if (res_timeout !== 1'b0 || res_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL after_to_result timeout=%b res_data=%0h expected 0/deadbeef", res_timeout, res_data);
        end
        release_result();
    endtask

    task automatic test_resp_hold();
        send(32'd2, 32'd2, 32'd2, 32'd2, 8'd40, 8'd41, 8'd42, 8'd43, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (cyc == 11) begin
                layerDone = 1'b1;
                layerOut  = 32'h1234;
            end
        end
        req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (req_ready !== 1'b0 || res_valid !== 1'b1 || res_data !== 32'h1234 || write !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable i=%0d ready=%b valid=%b data=%0h write=%b expected 0/1/1234/0", i, req_ready, res_valid, res_data, write);
            end
        end
        req_valid = 1'b0;
        release_result();
        checks++;
        if (req_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_release req_ready=%b res_valid=%b expected 1/0", req_ready, res_valid);
        end
    endtask

    task automatic test_reset_midjob();
        send(32'd3, 32'd3, 32'd3, 32'd3, 8'd50, 8'd51, 8'd52, 8'd53, 1'b1);
        for (int i = 1; i <= 5; i++) tick();
        checks++;
        if (write !== 1'b1 || address !== 2'd2 || weight !== 8'd52) begin
            errors++;
            $display("FAIL midjob_pre write=%b addr=%0d weight=%0d expected 1/2/52", write, address, weight);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (write !== 1'b0 || address !== 2'd0 || weight !== 8'd0 || input0 !== 0 ||
            layer_Sel !== 1'b0 || sumTrigger !== 1'b0 || res_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL midjob_async write=%b addr=%0d weight=%0d in0=%0h sel=%b ready=%b expected all 0",
                     write, address, weight, input0, layer_Sel, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send(32'd7, 32'd7, 32'd7, 32'd7, 8'd60, 8'd61, 8'd62, 8'd63, 1'b1);
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (cyc <= 8) begin
                checks++;
                if (write !== (cyc % 2 == 1) || address !== 2'((cyc - 1) / 2) || weight !== 8'(60 + (cyc - 1) / 2)) begin
                    errors++;
                    $display("FAIL midjob_rewrite cyc=%0d write=%b addr=%0d weight=%0d", cyc, write, address, weight);
                end
            end
            if (cyc == 11) begin
                layerDone = 1'b1;
                layerOut  = 32'd99;
            end
        end
        checks++;
        if (res_valid !== 1'b1 || res_data !== 32'd99 || input0 !== 32'd7) begin
            errors++;
            $display("FAIL midjob_result valid=%b data=%0d in0=%0d expected 1/99/7", res_valid, res_data, input0);
        end
        release_result();
    endtask

`ifdef NEURAL_DRIVER_WCACHE_EN
    task automatic test_wcache();
        int nw;
        nw = 0;
        send(32'd1, 32'd2, 32'd3, 32'd4, 8'd1, 8'd2, 8'd3, 8'd4, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (write === 1'b1) nw++;
            if (cyc == 11) layerDone = 1'b1;
        end
        checks++;
        if (nw != 4 || res_valid !== 1'b1) begin
            errors++;
            $display("FAIL wcache_first writes=%0d valid=%b expected 4/1", nw, res_valid);
        end
        release_result();

        send(32'd1, 32'd2, 32'd3, 32'd4, 8'd1, 8'd9, 8'd3, 8'd4, 1'b0);
        tick();
        checks++;
        if (write !== 1'b1 || address !== 2'd1 || weight !== 8'd9) begin
            errors++;
            $display("FAIL wcache_single write=%b addr=%0d weight=%0d expected 1/1/9", write, address, weight);
        end
        tick();
        tick();
        checks++;
        if (sumTrigger !== 1'b1 || write !== 1'b0) begin
            errors++;
            $display("FAIL wcache_trig3 sumTrigger=%b write=%b expected 1/0", sumTrigger, write);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (cyc == 5) layerDone = 1'b1;
        end
        checks++;
        if (res_valid !== 1'b1) begin
            errors++;
            $display("FAIL wcache_res2 res_valid=%b expected 1", res_valid);
        end
        release_result();

        send(32'd1, 32'd2, 32'd3, 32'd4, 8'd1, 8'd9, 8'd3, 8'd4, 1'b0);
        tick();
        checks++;
        if (sumTrigger !== 1'b1 || write !== 1'b0) begin
            errors++;
            $display("FAIL wcache_direct sumTrigger=%b write=%b expected 1/0", sumTrigger, write);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (cyc == 3) layerDone = 1'b1;
        end
        checks++;
        if (res_valid !== 1'b1) begin
            errors++;
            $display("FAIL wcache_res3 res_valid=%b expected 1", res_valid);
        end
        release_result();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_done_held();
        test_timeout();
        test_resp_hold();
        test_reset_midjob();
`ifdef NEURAL_DRIVER_WCACHE_EN
        test_wcache();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
